// File: rtl/csr_access_if.sv
// Bundles the EX request, WB response and CSR-file read/write signals of the CSR access unit.
// master = csr_access_unit side, slave = pipeline/CSR-file side.
interface csr_access_if #(
    parameter int XLEN   = 32,
    parameter int CSR_AW = 12
);
    logic              req_valid;
    logic              req_ready;
    logic [2:0]        req_funct3;
    logic [CSR_AW-1:0] req_addr;
    logic [XLEN-1:0]   req_rs1;
    logic [4:0]        req_uimm;
    logic              req_rd_nz;
    logic              csr_ren;
    logic [CSR_AW-1:0] csr_raddr;
    logic [XLEN-1:0]   csr_rdata;
    logic              csr_wen;
    logic [CSR_AW-1:0] csr_waddr;
    logic [XLEN-1:0]   csr_wdata;
    logic              resp_valid;
    logic              resp_ready;
    logic              resp_rd_we;
    logic [XLEN-1:0]   resp_rd_data;
    logic              resp_illegal;
    logic              busy;

    modport master (
        input  req_valid, req_funct3, req_addr, req_rs1, req_uimm, req_rd_nz,
        input  csr_rdata, resp_ready,
        output req_ready, csr_ren, csr_raddr, csr_wen, csr_waddr, csr_wdata,
        output resp_valid, resp_rd_we, resp_rd_data, resp_illegal, busy
    );

    modport slave (
        output req_valid, req_funct3, req_addr, req_rs1, req_uimm, req_rd_nz,
        output csr_rdata, resp_ready,
        input  req_ready, csr_ren, csr_raddr, csr_wen, csr_waddr, csr_wdata,
        input  resp_valid, resp_rd_we, resp_rd_data, resp_illegal, busy
    );
endinterface

// File: rtl/csr_access_unit.sv
// Zicsr executor: IDLE -> READ -> WRITE -> RESP read-modify-write sequence into the CSR file.
// Optional macro CSR_RO_CHECK_EN: writes to address space [11:10]==2'b11 are suppressed and flagged illegal.
module csr_access_unit #(
    parameter int XLEN   = 32,
    parameter int CSR_AW = 12
) (
    input  logic         clk,
    input  logic         rst_n,
    csr_access_if.master bus
);
    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_READ  = 2'd1;
    localparam logic [1:0] S_WRITE = 2'd2;
    localparam logic [1:0] S_RESP  = 2'd3;

    logic [1:0]        r_state;
    logic [2:0]        r_funct3;
    logic [CSR_AW-1:0] r_addr;
    logic [XLEN-1:0]   r_src;
    logic              r_rd_nz;
    logic              r_write_en;
    logic [XLEN-1:0]   r_old;

    logic              w_accept;
    logic [1:0]        w_op;
    logic              w_illegal_f3;
    logic              w_ro_viol;
    logic              w_ren;
    logic              w_wen;
    logic              w_illegal;
    logic [XLEN-1:0]   w_wdata;

    assign w_accept     = (r_state == S_IDLE) && bus.req_valid;
    assign w_op         = r_funct3[1:0];
    assign w_illegal_f3 = (w_op == 2'b00);

`ifdef CSR_RO_CHECK_EN
    assign w_ro_viol = r_write_en && (r_addr[CSR_AW-1 -: 2] == 2'b11);
`else
    assign w_ro_viol = 1'b0;
`endif

    // A plain swap into x0 has no architectural use for the old value, so skip the read side effect.
    assign w_ren = (r_state == S_READ) && !w_illegal_f3 && !((w_op == 2'b01) && !r_rd_nz);
    assign w_wen = (r_state == S_WRITE) && r_write_en && !w_ro_viol;
    assign w_illegal = w_illegal_f3 || w_ro_viol;

    always_comb begin
        w_wdata = '0;
        case (w_op)
            2'b01:   w_wdata = r_src;
            2'b10:   w_wdata = r_old | r_src;
            2'b11:   w_wdata = r_old & ~r_src;
            default: w_wdata = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_funct3   <= '0;
            r_addr     <= '0;
            r_src      <= '0;
            r_rd_nz    <= 1'b0;
            r_write_en <= 1'b0;
            r_old      <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_state  <= S_READ;
                        r_funct3 <= bus.req_funct3;
                        r_addr   <= bus.req_addr;
                        r_src    <= bus.req_funct3[2] ? {{(XLEN-5){1'b0}}, bus.req_uimm} : bus.req_rs1;
                        r_rd_nz  <= bus.req_rd_nz;
                        if (bus.req_funct3[1:0] == 2'b00)
                            r_write_en <= 1'b0;
                        else if (bus.req_funct3[1:0] == 2'b01)
                            r_write_en <= 1'b1;
                        else
                            r_write_en <= (bus.req_uimm != 5'd0);
                    end
                end
                S_READ: begin
                    r_old   <= w_ren ? bus.csr_rdata : '0;
                    r_state <= S_WRITE;
                end
                S_WRITE: r_state <= S_RESP;
                default: begin
                    if (bus.resp_ready)
                        r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.req_ready    = (r_state == S_IDLE);
    assign bus.busy         = (r_state != S_IDLE);
    assign bus.csr_ren      = w_ren;
    assign bus.csr_raddr    = r_addr;
    assign bus.csr_wen      = w_wen;
    assign bus.csr_waddr    = r_addr;
    assign bus.csr_wdata    = w_wdata;
    assign bus.resp_valid   = (r_state == S_RESP);
    assign bus.resp_illegal = (r_state == S_RESP) && w_illegal;
    assign bus.resp_rd_we   = (r_state == S_RESP) && r_rd_nz && !w_illegal;
    assign bus.resp_rd_data = (r_state == S_RESP) ? r_old : '0;
endmodule

// File: tb/tb_csr_access_unit.sv
// Directed bench for csr_access_unit with a one-register CSR file model driving csr_rdata.
module tb_csr_access_unit;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   failures = 0;
    logic [31:0] csr_val = 32'h0;

    csr_access_if #(.XLEN(32), .CSR_AW(12)) bus ();

    csr_access_unit #(.XLEN(32), .CSR_AW(12)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;
    assign bus.csr_rdata = bus.csr_ren ? csr_val : 32'h0;

    logic [4:0]  ren_m, wen_m, rv_m, rdy_m;
    logic [31:0] wd_obs, rdat_obs;
    logic [11:0] raddr_obs, waddr_obs;
    logic        rdwe_obs, ill_obs;

    // Issue one instruction at a negedge and record cycles 1..4 after the accepting edge.
    task automatic run_instr(input logic [2:0] f3, input logic [11:0] a, input logic [31:0] rs1,
                             input logic [4:0] u, input logic rdnz);
        ren_m = '0; wen_m = '0; rv_m = '0; rdy_m = '0;
        wd_obs = '0; rdat_obs = '0; raddr_obs = '0; waddr_obs = '0; rdwe_obs = 0; ill_obs = 0;
        bus.req_valid = 1'b1; bus.req_funct3 = f3; bus.req_addr = a;
        bus.req_rs1 = rs1; bus.req_uimm = u; bus.req_rd_nz = rdnz;
        @(posedge clk); #1 bus.req_valid = 1'b0;
        for (int c = 1; c <= 4; c++) begin
            @(negedge clk);
            ren_m[c] = bus.csr_ren;
            wen_m[c] = bus.csr_wen;
            rv_m[c]  = bus.resp_valid;
            rdy_m[c] = bus.req_ready;
            if (bus.csr_ren) raddr_obs = bus.csr_raddr;
            if (bus.csr_wen) begin wd_obs = bus.csr_wdata; waddr_obs = bus.csr_waddr; end
            if (c == 3) begin
                rdat_obs = bus.resp_rd_data; rdwe_obs = bus.resp_rd_we; ill_obs = bus.resp_illegal;
            end
        end
    endtask

    task automatic test_reset;
        repeat (3) @(negedge clk);
        checks++;
        if ({bus.req_ready, bus.busy, bus.csr_ren, bus.csr_wen, bus.resp_valid, bus.resp_rd_we, bus.resp_illegal} !== 7'b1000000) begin
            failures++; $display("FAIL reset_ctrl got=%b want=1000000", {bus.req_ready, bus.busy, bus.csr_ren, bus.csr_wen, bus.resp_valid, bus.resp_rd_we, bus.resp_illegal});
        end
        checks++;
        if ({bus.csr_raddr, bus.csr_waddr, bus.csr_wdata, bus.resp_rd_data} !== 88'h0) begin
            failures++; $display("FAIL reset_data got=%h want=0", {bus.csr_raddr, bus.csr_waddr, bus.csr_wdata, bus.resp_rd_data});
        end
        rst_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            checks++;
            if ({bus.req_ready, bus.busy, bus.csr_ren, bus.csr_wen, bus.resp_valid} !== 5'b10000) begin
                failures++; $display("FAIL idle_cyc%0d got=%b want=10000", i, {bus.req_ready, bus.busy, bus.csr_ren, bus.csr_wen, bus.resp_valid});
            end
        end
        $display("test_reset done checks=%0d failures=%0d", checks, failures);
    endtask

    task automatic test_rs_read_only;
        csr_val = 32'h0000_0005;
        run_instr(3'b010, 12'hC02, 32'h0, 5'd0, 1'b1);
        checks++; if (ren_m !== 5'b00010) begin failures++; $display("FAIL rs_ren_mask got=%b want=00010", ren_m); end
        checks++; if (raddr_obs !== 12'hC02) begin failures++; $display("FAIL rs_raddr got=%h want=c02", raddr_obs); end
        checks++; if (wen_m !== 5'b00000) begin failures++; $display("FAIL rs_wen_mask got=%b want=00000", wen_m); end
        checks++; if (rv_m !== 5'b01000) begin failures++; $display("FAIL rs_resp_mask got=%b want=01000", rv_m); end
        checks++; if (rdat_obs !== 32'h5) begin failures++; $display("FAIL rs_rd_data got=%h want=5", rdat_obs); end
        checks++; if ({rdwe_obs, ill_obs} !== 2'b10) begin failures++; $display("FAIL rs_we_ill got=%b want=10", {rdwe_obs, ill_obs}); end
        $display("test_rs_read_only done checks=%0d failures=%0d", checks, failures);
    endtask

    task automatic test_rw_no_read;
        csr_val = 32'h1234_5678;
        run_instr(3'b001, 12'h340, 32'hDEAD_BEEF, 5'd7, 1'b0);
        checks++; if (ren_m !== 5'b00000) begin failures++; $display("FAIL rw_ren_mask got=%b want=00000", ren_m); end
        checks++; if (wen_m !== 5'b00100) begin failures++; $display("FAIL rw_wen_mask got=%b want=00100", wen_m); end
        checks++; if (wd_obs !== 32'hDEAD_BEEF) begin failures++; $display("FAIL rw_wdata got=%h want=deadbeef", wd_obs); end
        checks++; if (waddr_obs !== 12'h340) begin failures++; $display("FAIL rw_waddr got=%h want=340", waddr_obs); end
        checks++; if ({rdwe_obs, ill_obs, rdat_obs} !== 34'h0) begin failures++; $display("FAIL rw_resp got=%b/%b/%h want=0/0/0", rdwe_obs, ill_obs, rdat_obs); end
        $display("test_rw_no_read done checks=%0d failures=%0d", checks, failures);
    endtask

    task automatic test_rci;
        csr_val = 32'h0000_00FF;
        run_instr(3'b111, 12'h300, 32'hFFFF_FFFF, 5'b00011, 1'b1);
        checks++; if (ren_m !== 5'b00010) begin failures++; $display("FAIL rci_ren_mask got=%b want=00010", ren_m); end
        checks++; if (wen_m !== 5'b00100) begin failures++; $display("FAIL rci_wen_mask got=%b want=00100", wen_m); end
        checks++; if (wd_obs !== 32'h0000_00FC) begin failures++; $display("FAIL rci_wdata got=%h want=000000fc", wd_obs); end
        checks++; if (rdat_obs !== 32'h0000_00FF) begin failures++; $display("FAIL rci_rd_data got=%h want=000000ff", rdat_obs); end
        $display("test_rci done checks=%0d failures=%0d", checks, failures);
    endtask

    task automatic test_rs_set;
        csr_val = 32'h8000_000F;
        run_instr(3'b010, 12'h304, 32'h0000_0F00, 5'd9, 1'b1);
        checks++; if (wd_obs !== 32'h8000_0F0F) begin failures++; $display("FAIL rs_set_wdata got=%h want=80000f0f", wd_obs); end
        checks++; if (wen_m !== 5'b00100) begin failures++; $display("FAIL rs_set_wen got=%b want=00100", wen_m); end
        $display("test_rs_set done checks=%0d failures=%0d", checks, failures);
    endtask

    task automatic test_ro_space;
        csr_val = 32'h0000_0042;
        run_instr(3'b001, 12'hC00, 32'h0000_0001, 5'd1, 1'b1);
        checks++; if (ren_m !== 5'b00010) begin failures++; $display("FAIL ro_ren_mask got=%b want=00010", ren_m); end
`ifdef CSR_RO_CHECK_EN
        checks++; if (wen_m !== 5'b00000) begin failures++; $display("FAIL ro_wen_mask got=%b want=00000", wen_m); end
        checks++; if ({rdwe_obs, ill_obs} !== 2'b01) begin failures++; $display("FAIL ro_we_ill got=%b want=01", {rdwe_obs, ill_obs}); end
`else
        checks++; if (wen_m !== 5'b00100) begin failures++; $display("FAIL ro_wen_mask got=%b want=00100", wen_m); end
        checks++; if ({rdwe_obs, ill_obs} !== 2'b10) begin failures++; $display("FAIL ro_we_ill got=%b want=10", {rdwe_obs, ill_obs}); end
        checks++; if (wd_obs !== 32'h1) begin failures++; $display("FAIL ro_wdata got=%h want=1", wd_obs); end
`endif
        checks++; if (rdat_obs !== 32'h42) begin failures++; $display("FAIL ro_rd_data got=%h want=42", rdat_obs); end
        $display("test_ro_space done checks=%0d failures=%0d", checks, failures);
    endtask

    task automatic test_illegal;
        csr_val = 32'h0000_00AA;
        run_instr(3'b100, 12'h300, 32'h1, 5'd3, 1'b1);
        checks++; if ({ren_m, wen_m} !== 10'b0) begin failures++; $display("FAIL ill_access got=%b/%b want=0/0", ren_m, wen_m); end
        checks++; if ({rdwe_obs, ill_obs} !== 2'b01) begin failures++; $display("FAIL ill_we_ill got=%b want=01", {rdwe_obs, ill_obs}); end
        checks++; if (rv_m !== 5'b01000) begin failures++; $display("FAIL ill_resp_mask got=%b want=01000", rv_m); end
        $display("test_illegal done checks=%0d failures=%0d", checks, failures);
    endtask

    task automatic test_back_to_back;
        csr_val = 32'h0000_0010;
        run_instr(3'b010, 12'h341, 32'h0, 5'd0, 1'b1);
        checks++; if (rdy_m !== 5'b10000) begin failures++; $display("FAIL b2b_ready_mask got=%b want=10000", rdy_m); end
        csr_val = 32'h0000_0020;
        run_instr(3'b110, 12'h342, 32'h0, 5'd1, 1'b1);
        checks++; if (rv_m !== 5'b01000) begin failures++; $display("FAIL b2b_resp_mask got=%b want=01000", rv_m); end
        checks++; if (wd_obs !== 32'h21) begin failures++; $display("FAIL b2b_wdata got=%h want=21", wd_obs); end
        checks++; if (rdat_obs !== 32'h20) begin failures++; $display("FAIL b2b_rd_data got=%h want=20", rdat_obs); end
        $display("test_back_to_back done checks=%0d failures=%0d", checks, failures);
    endtask

    task automatic test_reset_mid_op;
        csr_val = 32'h0;
        bus.req_valid = 1'b1; bus.req_funct3 = 3'b010; bus.req_addr = 12'h300;
        bus.req_rs1 = 32'h1; bus.req_uimm = 5'd1; bus.req_rd_nz = 1'b1;
        @(posedge clk); #1 bus.req_valid = 1'b0;
        @(negedge clk);
        checks++; if (bus.busy !== 1'b1) begin failures++; $display("FAIL mid_busy_read got=%b want=1", bus.busy); end
        rst_n = 1'b0;
        #1;
        checks++;
        if ({bus.busy, bus.req_ready, bus.csr_ren, bus.csr_wen} !== 4'b0100) begin
            failures++; $display("FAIL mid_async_idle got=%b want=0100", {bus.busy, bus.req_ready, bus.csr_ren, bus.csr_wen});
        end
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (i == 1) rst_n = 1'b1;
            checks++;
            if ({bus.busy, bus.csr_wen, bus.resp_valid} !== 3'b000) begin
                failures++; $display("FAIL mid_after_cyc%0d got=%b want=000", i, {bus.busy, bus.csr_wen, bus.resp_valid});
            end
        end
        $display("test_reset_mid_op done checks=%0d failures=%0d", checks, failures);
    endtask

    task automatic test_resp_hold;
        csr_val = 32'h0000_0033;
        bus.resp_ready = 1'b0;
        bus.req_valid = 1'b1; bus.req_funct3 = 3'b010; bus.req_addr = 12'h305;
        bus.req_rs1 = 32'h0000_0100; bus.req_uimm = 5'd2; bus.req_rd_nz = 1'b1;
        @(posedge clk); #1 bus.req_valid = 1'b0;
        repeat (3) @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            checks++;
            if ({bus.resp_valid, bus.resp_rd_we, bus.resp_illegal, bus.resp_rd_data, bus.csr_ren, bus.csr_wen, bus.req_ready}
                !== {3'b110, 32'h0000_0033, 3'b000}) begin
                failures++; $display("FAIL hold_cyc%0d valid=%b we=%b ill=%b data=%h ren=%b wen=%b rdy=%b want 1/1/0/33/0/0/0",
                    i, bus.resp_valid, bus.resp_rd_we, bus.resp_illegal, bus.resp_rd_data, bus.csr_ren, bus.csr_wen, bus.req_ready);
            end
            @(negedge clk);
        end
        bus.resp_ready = 1'b1;
        @(negedge clk);
        checks++;
        if ({bus.resp_valid, bus.req_ready, bus.busy} !== 3'b010) begin
            failures++; $display("FAIL hold_release got=%b want=010", {bus.resp_valid, bus.req_ready, bus.busy});
        end
        $display("test_resp_hold done checks=%0d failures=%0d", checks, failures);
    endtask

    initial begin
        bus.req_valid = 1'b0; bus.req_funct3 = 3'b000; bus.req_addr = '0;
        bus.req_rs1 = '0; bus.req_uimm = '0; bus.req_rd_nz = 1'b0; bus.resp_ready = 1'b1;
        test_reset();
        test_rs_read_only();
        test_rw_no_read();
        test_rci();
        test_rs_set();
        test_ro_space();
        test_illegal();
        test_back_to_back();
        test_reset_mid_op();
        test_resp_hold();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
